// File: rtl/rob_retire.sv
// In-order ROB retirement: allocates tags, tracks completions, retires via the head read port.
// Latency: done at cycle N -> retire_valid_o at N+2. The output stage reloads only when empty or being consumed.
module rob_retire #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_req_i,
    output logic                  alloc_gnt_o,
    output logic [ADDR_WIDTH-1:0] alloc_tag_o,
    input  logic                  done_i,
    input  logic [ADDR_WIDTH-1:0] done_tag_i,
    output logic                  done_err_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_read_o,
    input  logic [DATA_WIDTH-1:0] mem_data_read_i,
    output logic                  retire_valid_o,
    input  logic                  retire_ready_i,
    output logic [DATA_WIDTH-1:0] retire_data_o,
    output logic [ADDR_WIDTH-1:0] retire_tag_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam int                DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH:0]   head_q, head_d, tail_q, tail_d, count;
    logic [DEPTH-1:0]      done_q, done_d;
    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic                  err_q, err_d;

    logic [ADDR_WIDTH-1:0] head_idx, tail_idx, done_offset;
    logic                  alloc_fire, tag_alloc, load;

    assign count       = tail_q - head_q;
    assign head_idx    = head_q[ADDR_WIDTH-1:0];
    assign tail_idx    = tail_q[ADDR_WIDTH-1:0];
    assign alloc_fire  = alloc_req_i && (count != FULL);
    // Distance from head decides whether the completing tag is live.
    assign done_offset = done_tag_i - head_idx;
    assign tag_alloc   = ({1'b0, done_offset} < count);
    assign load        = (count != '0) && done_q[head_idx] && (!valid_q || retire_ready_i);

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        done_d  = done_q;
        valid_d = valid_q;
        data_d  = data_q;
        tag_d   = tag_q;
        err_d   = done_i && !tag_alloc;

        if (alloc_fire) begin
            tail_d           = tail_q + 1'b1;
            done_d[tail_idx] = 1'b0;
        end
        if (done_i && tag_alloc) begin
            done_d[done_tag_i] = 1'b1;
        end
        if (load) begin
            valid_d          = 1'b1;
            data_d           = mem_data_read_i;
            tag_d            = head_idx;
            done_d[head_idx] = 1'b0;
            head_d           = head_q + 1'b1;
        end else if (valid_q && retire_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            done_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            tag_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            tag_q   <= tag_d;
            err_q   <= err_d;
        end
    end

    assign alloc_gnt_o     = (count != FULL);
    assign alloc_tag_o     = tail_idx;
    assign mem_addr_read_o = head_idx;
    assign done_err_o      = err_q;
    assign retire_valid_o  = valid_q;
    assign retire_data_o   = data_q;
    assign retire_tag_o    = tag_q;
    assign count_o         = count;

endmodule

// File: doc/rob_retire.md
# rob_retire

In-order retirement controller for the reorder buffer. It allocates entry tags in program order, records out-of-order completions, and reads completed entries from the external simple dual-port data memory strictly in allocation order. Retired entries are presented on a registered valid/ready stream. The block is the read-side owner of the ROB data memory; producers write data into that memory themselves.

## Interface
- ADDR_WIDTH, 4, tag/address width; DEPTH = 2**ADDR_WIDTH entries
- DATA_WIDTH, 8, entry data width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- alloc_req_i  in  1  request one new entry this cycle
- alloc_gnt_o  out  1  combinational; = (count_o != DEPTH); allocation happens iff alloc_req_i && alloc_gnt_o
- alloc_tag_o  out  ADDR_WIDTH  tag granted this cycle (= tail pointer low bits)
- done_i  in  1  completion strobe; producer writes entry data to memory with the same edge
- done_tag_i  in  ADDR_WIDTH  tag being completed
- done_err_o  out  1  registered one-cycle pulse: done_i hit an unallocated tag
- mem_addr_read_o  out  ADDR_WIDTH  memory read address (= head pointer low bits)
- mem_data_read_i  in  DATA_WIDTH  combinational read data from memory
- retire_valid_o  out  1  registered output stage holds a retired entry
- retire_ready_i  in  1  consumer accepts
- retire_data_o  out  DATA_WIDTH  retired entry data
- retire_tag_o  out  ADDR_WIDTH  retired entry tag
- count_o  out  ADDR_WIDTH+1  entries allocated and not yet moved to output stage

## Operation
- head, tail: ADDR_WIDTH+1-bit pointers (extra wrap bit); count = tail - head, mod 2**(ADDR_WIDTH+1).
- done[DEPTH]: per-entry completion bits, cleared on reset.
- Allocate: on alloc_req_i && alloc_gnt_o, tail += 1; done[tail] cleared. When full, the request is ignored with no state change.
- Complete: a tag is allocated iff (done_tag_i - head[ADDR_WIDTH-1:0]) mod DEPTH < count.
  - Allocated tag: done[tag] <= 1.
  - Unallocated tag: no state change; done_err_o = 1 on the next cycle.
  - Repeated done on an already-done tag has no effect and is not an error.
- Advance (load): the condition is count != 0 && done[head] && (!retire_valid_o || retire_ready_i). On load:
  - retire_data_o <= mem_data_read_i, retire_tag_o <= head low bits, retire_valid_o <= 1.
  - done[head] <= 0, head += 1.
- Consume: retire_valid_o && retire_ready_i with no load in the same cycle sets retire_valid_o <= 0.
- While retire_valid_o && !retire_ready_i, retire_data_o and retire_tag_o stay stable.
- The slot is freed at load. The output register holds the only copy, so the slot may be re-allocated immediately.
- Simultaneous events:
  - Alloc and load in the same cycle leave count unchanged.
  - Alloc and done to the tag being allocated: the done is an error (tag not yet allocated).
  - Load and done to the same head entry cannot collide, because done[head] is already 1 when loading.
- Pointer wrap: tags wrap DEPTH-1 -> 0; the full/empty distinction comes from the wrap bit only.

## Timing
- Reset (async assert, sync deassert handled upstream) sets:
  - head = tail = 0, all done = 0.
  - retire_valid_o = 0, retire_data_o = 0, retire_tag_o = 0.
  - done_err_o = 0, count_o = 0.
  - alloc_tag_o = 0, mem_addr_read_o = 0, alloc_gnt_o = 1.
- Reset asserted mid-operation discards all entries and the output stage immediately. No retire occurs after reset for entries allocated before it.
- Latency: done_i for the head tag in cycle N -> retire_valid_o = 1 in cycle N+2. There is no same-cycle bypass.
- Throughput: one retire per cycle when entries are done and retire_ready_i is held 1.
- alloc_gnt_o, alloc_tag_o and mem_addr_read_o are combinational from registers only, with no input-to-output paths. The exception is the mem_data_read_i -> output register path.
- count_o updates on the edge after alloc or load.

## Test plan
- Reset, then alloc 3 entries (tags 0,1,2), then done tags 2,1,0 with data 0xA2,0xA1,0xA0, retire_ready_i=1 -> retire tags 0,1,2 in order with data 0xA0,0xA1,0xA2. The first valid appears 2 cycles after done of tag 0.
- Alloc 16 with no done -> count_o=16, alloc_gnt_o=0, a 17th request is ignored. Done tag 0 -> after retire, count_o=15 and alloc_gnt_o=1.
- Backpressure: 4 entries done, retire_ready_i=0 for 5 cycles -> retire_valid_o=1 with tag 0 and data held stable, count_o=3. Release ready -> tags 0..3 on consecutive cycles.
- Wrap: 40 cycles of continuous alloc, done one cycle later, ready=1 -> tags retire 0..15,0..15,0..7 in order, data matches, no done_err_o.
- done_i with tag 5 while only tags 0..2 are allocated -> done_err_o pulses 1 cycle later, no retire of tag 5, and later alloc of tag 5 starts not-done.
- Assert rst_n=0 while retire_valid_o=1 and count_o=6 -> all outputs take their reset values immediately. After release, alloc_tag_o=0 and the old entries never retire.
